// File: rtl/ft245_tx_arbiter_if.sv
// ft245_tx_arbiter_if
//   Bundles the signals between the TX arbiter, its byte producers and the
//   FTDI controller TX byte channel.
//   master : arbiter side (drives out_* toward producers and the FTDI controller)
//   slave  : environment side (producers drive in_req/in_data/in_lock, the FTDI
//            controller drives in_tx_hsk_ack)
//   Signals:
//     in_req[N]       per-requester byte request (4-phase, data stable while high)
//     out_ack[N]      per-requester ack (4-phase)
//     in_data[8N]     requester i byte on [8*i+7:8*i]
//     in_lock[N]      requester i keeps the grant after the current byte
//     out_grant[N]    one-hot current owner, 0 when idle
//     out_busy        arbiter not idle
//     out_tx_hsk_req  request to the FTDI controller
//     in_tx_hsk_ack   ack from the FTDI controller
//     out_tx_data[8]  byte to the FTDI controller
interface ft245_tx_arbiter_if #(
    parameter int unsigned ARB_REQ_NUM_OF = 2
);
    logic [ARB_REQ_NUM_OF-1:0]   in_req;
    logic [ARB_REQ_NUM_OF-1:0]   out_ack;
    logic [8*ARB_REQ_NUM_OF-1:0] in_data;
    logic [ARB_REQ_NUM_OF-1:0]   in_lock;
    logic [ARB_REQ_NUM_OF-1:0]   out_grant;
    logic                        out_busy;
    logic                        out_tx_hsk_req;
    logic                        in_tx_hsk_ack;
    logic [7:0]                  out_tx_data;

    modport master (
        input  in_req, in_data, in_lock, in_tx_hsk_ack,
        output out_ack, out_grant, out_busy, out_tx_hsk_req, out_tx_data
    );

    modport slave (
        output in_req, in_data, in_lock, in_tx_hsk_ack,
        input  out_ack, out_grant, out_busy, out_tx_hsk_req, out_tx_data
    );
endinterface

// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter
//   Shares the single FTDI TX byte channel among ARB_REQ_NUM_OF producers.
//   Round-robin grant per byte; a producer holding in_lock keeps the grant for
//   up to ARB_BURST_MAX consecutive bytes, after which it is forced to release.
//   Ports:
//     in_clk    system clock (clk_top_main)
//     in_rst_n  asynchronous active-low reset
//     bus       ft245_tx_arbiter_if.master (producer and FTDI handshakes)
//   All outputs are registered.
module ft245_tx_arbiter #(
    parameter int unsigned ARB_REQ_NUM_OF = 2,
    parameter int unsigned ARB_BURST_MAX  = 16
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    ft245_tx_arbiter_if.master bus
);
    localparam int unsigned N  = ARB_REQ_NUM_OF;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RELEASE,
        HOLD
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] g_idx;
    logic [7:0]    burst_cnt;

    logic          sel_valid;
    logic [PW-1:0] sel_idx;
    logic [N-1:0]  sel_onehot;
    logic [PW-1:0] next_ptr;
    logic [8:0]    burst_inc;

    // First asserted request at or after rr_ptr, wrapping N-1 -> 0.
    always_comb begin
        int unsigned   cand_i;
        logic [PW-1:0] cand;
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand_i    = 0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand_i = 32'(rr_ptr) + k;
            if (cand_i >= N) begin
                cand_i = cand_i - N;
            end
            cand = PW'(cand_i);
            if (!sel_valid && bus.in_req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_onehot = N'(1) << sel_idx;
        next_ptr   = (g_idx == PW'(N - 1)) ? '0 : g_idx + 1'b1;
        burst_inc  = {1'b0, burst_cnt} + 9'd1;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            g_idx              <= '0;
            burst_cnt          <= '0;
            bus.out_ack        <= '0;
            bus.out_grant      <= '0;
            bus.out_busy       <= 1'b0;
            bus.out_tx_hsk_req <= 1'b0;
            bus.out_tx_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        g_idx           <= sel_idx;
                        bus.out_grant   <= sel_onehot;
                        bus.out_tx_data <= bus.in_data[{sel_idx, 3'b000} +: 8];
                        bus.out_busy    <= 1'b1;
                        state           <= SEND;
                    end
                end

                SEND: begin
                    if (!bus.out_tx_hsk_req) begin
                        // Only open a new handshake once the previous ack is gone.
                        if (!bus.in_tx_hsk_ack) begin
                            bus.out_tx_hsk_req <= 1'b1;
                        end
                    end else if (bus.in_tx_hsk_ack) begin
                        bus.out_tx_hsk_req <= 1'b0;
                        bus.out_ack        <= bus.out_grant;
                        state              <= RELEASE;
                    end
                end

                RELEASE: begin
                    if (!bus.in_tx_hsk_ack && !bus.in_req[g_idx]) begin
                        bus.out_ack <= '0;
                        // Limit is checked against the count including this byte.
                        if (bus.in_lock[g_idx] && (burst_inc < 9'(ARB_BURST_MAX))) begin
                            burst_cnt <= burst_inc[7:0];
                            state     <= HOLD;
                        end else begin
                            rr_ptr        <= next_ptr;
                            burst_cnt     <= '0;
                            bus.out_grant <= '0;
                            bus.out_busy  <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end

                HOLD: begin
                    if (bus.in_req[g_idx]) begin
                        bus.out_tx_data <= bus.in_data[{g_idx, 3'b000} +: 8];
                        state           <= SEND;
                    end else if (!bus.in_lock[g_idx]) begin
                        rr_ptr        <= next_ptr;
                        burst_cnt     <= '0;
                        bus.out_grant <= '0;
                        bus.out_busy  <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// tb_ft245_tx_arbiter
//   Directed bench for ft245_tx_arbiter: a 2-requester instance for the main
//   scenarios and a 3-requester instance for the round-robin wrap case.
module tb_ft245_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    ft245_tx_arbiter_if #(.ARB_REQ_NUM_OF(2)) if2 ();
    ft245_tx_arbiter_if #(.ARB_REQ_NUM_OF(3)) if3 ();

    ft245_tx_arbiter #(.ARB_REQ_NUM_OF(2), .ARB_BURST_MAX(16)) dut2 (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (if2.master)
    );

    ft245_tx_arbiter #(.ARB_REQ_NUM_OF(3), .ARB_BURST_MAX(16)) dut3 (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (if3.master)
    );

    // producer / FTDI model state for the automatic runs on the 2-port instance
    int         prod_left[2];
    int         prod_sent[2];
    int         prod_start[2];
    bit         lock_en[2];
    logic [1:0] log_grant[$];
    logic [7:0] log_data[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        if2.in_req = '0; if2.in_data = '0; if2.in_lock = '0; if2.in_tx_hsk_ack = 1'b0;
        if3.in_req = '0; if3.in_data = '0; if3.in_lock = '0; if3.in_tx_hsk_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_hsk2(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (if2.out_tx_hsk_req) ok = 1'b1;
        end
    endtask

    task automatic wait_hsk3(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (if3.out_tx_hsk_req) ok = 1'b1;
        end
    endtask

    // Cycle-stepped producers + FTDI responder (ack 2 cycles after req).
    task automatic run_auto2(input int budget, output bit done);
        logic       prev_req;
        logic [7:0] prev_data;
        int         ftdi_cnt;
        done = 1'b0; prev_req = 1'b0; prev_data = '0; ftdi_cnt = 0;
        log_grant.delete(); log_data.delete();
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (!$onehot0(if2.out_ack) || ((if2.out_ack & ~if2.out_grant) != 2'b00)) begin
                n_fail++;
                $display("FAIL ack_within_grant: ack=%b grant=%b, required ack one-hot inside grant", if2.out_ack, if2.out_grant);
            end
            if (prev_req && if2.out_tx_hsk_req) begin
                n_checks++;
                if (if2.out_tx_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL tx_data_stable: got %h required %h", if2.out_tx_data, prev_data);
                end
            end
            prev_req  = if2.out_tx_hsk_req;
            prev_data = if2.out_tx_data;
            if (if2.out_tx_hsk_req && !if2.in_tx_hsk_ack) begin
                ftdi_cnt++;
                if (ftdi_cnt >= 2) begin
                    log_grant.push_back(if2.out_grant);
                    log_data.push_back(if2.out_tx_data);
                    if2.in_tx_hsk_ack = 1'b1;
                    ftdi_cnt = 0;
                end
            end else if (!if2.out_tx_hsk_req && if2.in_tx_hsk_ack) begin
                if2.in_tx_hsk_ack = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (if2.in_req[i] && if2.out_ack[i]) begin
                    if2.in_req[i] = 1'b0;
                end else if (!if2.in_req[i] && !if2.out_ack[i] && prod_left[i] > 0 && cyc >= prod_start[i]) begin
                    if2.in_data[8*i +: 8] = 8'(i * 64 + prod_sent[i]);
                    prod_sent[i]++;
                    prod_left[i]--;
                    if2.in_lock[i] = lock_en[i] && (prod_left[i] > 0);
                    if2.in_req[i]  = 1'b1;
                end
            end
            if (prod_left[0] == 0 && prod_left[1] == 0 && if2.in_req == 2'b00 &&
                !if2.out_busy && !if2.in_tx_hsk_ack) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if2.out_ack, if2.out_grant, if2.out_busy, if2.out_tx_hsk_req, if2.out_tx_data} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_n2: ack=%b grant=%b busy=%b req=%b data=%h, required all 0",
                     if2.out_ack, if2.out_grant, if2.out_busy, if2.out_tx_hsk_req, if2.out_tx_data);
        end
        n_checks++;
        if ({if3.out_ack, if3.out_grant, if3.out_busy, if3.out_tx_hsk_req, if3.out_tx_data} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_n3: ack=%b grant=%b busy=%b, required all 0", if3.out_ack, if3.out_grant, if3.out_busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({if2.out_grant, if2.out_busy, if2.out_tx_hsk_req} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle_after_release: grant=%b busy=%b req=%b, required 0", if2.out_grant, if2.out_busy, if2.out_tx_hsk_req);
        end
    endtask

    task automatic test_single();
        do_reset();
        if2.in_data[7:0] = 8'hA5;
        if2.in_req = 2'b01;
        @(negedge clk);
        n_checks++;
        if ({if2.out_tx_hsk_req, if2.out_grant, if2.out_busy, if2.out_tx_data} !== {1'b0, 2'b01, 1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_latch: req=%b grant=%b busy=%b data=%h, required 0 01 1 a5",
                     if2.out_tx_hsk_req, if2.out_grant, if2.out_busy, if2.out_tx_data);
        end
        @(negedge clk);
        n_checks++;
        if (if2.out_tx_hsk_req !== 1'b1) begin
            n_fail++;
            $display("FAIL single_req_latency: tx_hsk_req=%b 2 clk after req, required 1", if2.out_tx_hsk_req);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({if2.out_tx_hsk_req, if2.out_ack} !== {1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL single_wait_ack: req=%b ack=%b, required 1 00", if2.out_tx_hsk_req, if2.out_ack);
        end
        if2.in_tx_hsk_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({if2.out_tx_hsk_req, if2.out_ack} !== {1'b0, 2'b01}) begin
            n_fail++;
            $display("FAIL single_ack: req=%b ack=%b, required 0 01", if2.out_tx_hsk_req, if2.out_ack);
        end
        if2.in_req = 2'b00;
        if2.in_tx_hsk_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if2.out_ack, if2.out_grant, if2.out_busy, if2.out_tx_hsk_req} !== 6'b0) begin
            n_fail++;
            $display("FAIL single_back_idle: ack=%b grant=%b busy=%b req=%b, required 0",
                     if2.out_ack, if2.out_grant, if2.out_busy, if2.out_tx_hsk_req);
        end
    endtask

    task automatic test_back_to_back();
        bit done;
        logic [1:0] exp_g[6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] exp_d[6] = '{8'h00, 8'h40, 8'h01, 8'h41, 8'h02, 8'h42};
        do_reset();
        prod_left  = '{3, 3};
        prod_sent  = '{0, 0};
        prod_start = '{0, 0};
        lock_en    = '{1'b0, 1'b0};
        run_auto2(400, done);
        n_checks++;
        if (!done || log_grant.size() != 6) begin
            n_fail++;
            $display("FAIL b2b_complete: done=%0d bytes=%0d, required done=1 bytes=6", done, log_grant.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if ({log_grant[k], log_data[k]} !== {exp_g[k], exp_d[k]}) begin
                    n_fail++;
                    $display("FAIL b2b_byte%0d: grant=%b data=%h, required %b %h", k, log_grant[k], log_data[k], exp_g[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_lock_burst();
        bit done;
        logic [1:0] exp_g[$];
        logic [7:0] exp_d[$];
        for (int k = 0; k < 16; k++) begin exp_g.push_back(2'b10); exp_d.push_back(8'(64 + k)); end
        exp_g.push_back(2'b01); exp_d.push_back(8'h00);
        for (int k = 16; k < 20; k++) begin exp_g.push_back(2'b10); exp_d.push_back(8'(64 + k)); end
        do_reset();
        prod_left  = '{1, 20};
        prod_sent  = '{0, 0};
        prod_start = '{5, 0};
        lock_en    = '{1'b0, 1'b1};
        run_auto2(1500, done);
        n_checks++;
        if (!done || log_grant.size() != 21) begin
            n_fail++;
            $display("FAIL lock_complete: done=%0d bytes=%0d, required done=1 bytes=21", done, log_grant.size());
        end else begin
            for (int k = 0; k < 21; k++) begin
                n_checks++;
                if ({log_grant[k], log_data[k]} !== {exp_g[k], exp_d[k]}) begin
                    n_fail++;
                    $display("FAIL lock_byte%0d: grant=%b data=%h, required %b %h", k, log_grant[k], log_data[k], exp_g[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_ack_hold();
        bit ok;
        do_reset();
        if2.in_data = {8'h7E, 8'h3C};
        if2.in_req = 2'b01;
        wait_hsk2(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL hold_first_req: tx_hsk_req never rose, required 1");
        end
        if2.in_tx_hsk_ack = 1'b1;
        if2.in_req = 2'b11;
        @(negedge clk);
        n_checks++;
        if ({if2.out_tx_hsk_req, if2.out_ack} !== {1'b0, 2'b01}) begin
            n_fail++;
            $display("FAIL hold_ack0: req=%b ack=%b, required 0 01", if2.out_tx_hsk_req, if2.out_ack);
        end
        if2.in_req = 2'b10;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({if2.out_tx_hsk_req, if2.out_tx_data, if2.out_grant} !== {1'b0, 8'h3C, 2'b01}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: req=%b data=%h grant=%b, required 0 3c 01",
                         c, if2.out_tx_hsk_req, if2.out_tx_data, if2.out_grant);
            end
        end
        if2.in_tx_hsk_ack = 1'b0;
        wait_hsk2(10, ok);
        n_checks++;
        if (!ok || {if2.out_tx_data, if2.out_grant} !== {8'h7E, 2'b10}) begin
            n_fail++;
            $display("FAIL hold_second_byte: seen=%0d data=%h grant=%b, required 1 7e 10", ok, if2.out_tx_data, if2.out_grant);
        end
        if2.in_tx_hsk_ack = 1'b1;
        @(negedge clk);
        if2.in_req = 2'b00;
        if2.in_tx_hsk_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if2.out_ack, if2.out_grant, if2.out_busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL hold_idle: ack=%b grant=%b busy=%b, required 0", if2.out_ack, if2.out_grant, if2.out_busy);
        end
    endtask

    task automatic test_early_drop();
        bit ok;
        do_reset();
        if2.in_data[7:0] = 8'h5A;
        if2.in_req = 2'b01;
        @(negedge clk);
        if2.in_req = 2'b00;
        wait_hsk2(10, ok);
        n_checks++;
        if (!ok || if2.out_tx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL early_drop_sent: seen=%0d data=%h, required 1 5a", ok, if2.out_tx_data);
        end
        if2.in_tx_hsk_ack = 1'b1;
        @(negedge clk);
        if2.in_tx_hsk_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if2.out_ack, if2.out_grant, if2.out_busy, if2.out_tx_hsk_req} !== 6'b0) begin
            n_fail++;
            $display("FAIL early_drop_idle: ack=%b grant=%b busy=%b req=%b, required 0",
                     if2.out_ack, if2.out_grant, if2.out_busy, if2.out_tx_hsk_req);
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int high_cnt;
        do_reset();
        if2.in_data[7:0] = 8'h11;
        if2.in_req = 2'b01;
        wait_hsk2(10, ok);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!ok || {if2.out_ack, if2.out_grant, if2.out_busy, if2.out_tx_hsk_req, if2.out_tx_data} !== 14'h0) begin
            n_fail++;
            $display("FAIL rst_mid_send: seen=%0d ack=%b grant=%b busy=%b req=%b data=%h, required all 0",
                     ok, if2.out_ack, if2.out_grant, if2.out_busy, if2.out_tx_hsk_req, if2.out_tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_hsk2(10, ok);
        n_checks++;
        if (!ok || {if2.out_tx_data, if2.out_grant} !== {8'h11, 2'b01}) begin
            n_fail++;
            $display("FAIL rst_rearb: seen=%0d data=%h grant=%b, required 1 11 01", ok, if2.out_tx_data, if2.out_grant);
        end
        if2.in_tx_hsk_ack = 1'b1;
        @(negedge clk);
        if2.in_req = 2'b00;
        if2.in_tx_hsk_ack = 1'b0;
        high_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if2.out_tx_hsk_req) high_cnt++;
        end
        n_checks++;
        if (high_cnt != 0 || if2.out_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_served_once: extra req cycles=%0d busy=%b, required 0 0", high_cnt, if2.out_busy);
        end
    endtask

    task automatic test_rr_wrap_n3();
        bit ok;
        do_reset();
        if3.in_data[7:0] = 8'h10;
        if3.in_req = 3'b001;
        wait_hsk3(10, ok);
        if3.in_tx_hsk_ack = 1'b1;
        @(negedge clk);
        if3.in_req = 3'b000;
        if3.in_tx_hsk_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!ok || if3.out_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr3_first_byte: seen=%0d busy=%b, required 1 0", ok, if3.out_busy);
        end
        if3.in_data = {8'hC2, 8'hC1, 8'hC0};
        if3.in_req = 3'b101;
        wait_hsk3(10, ok);
        n_checks++;
        if (!ok || {if3.out_grant, if3.out_tx_data} !== {3'b100, 8'hC2}) begin
            n_fail++;
            $display("FAIL rr3_serve2: seen=%0d grant=%b data=%h, required 1 100 c2", ok, if3.out_grant, if3.out_tx_data);
        end
        if3.in_tx_hsk_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (if3.out_ack !== 3'b100) begin
            n_fail++;
            $display("FAIL rr3_ack2: ack=%b, required 100", if3.out_ack);
        end
        if3.in_req[2] = 1'b0;
        if3.in_tx_hsk_ack = 1'b0;
        wait_hsk3(10, ok);
        n_checks++;
        if (!ok || {if3.out_grant, if3.out_tx_data} !== {3'b001, 8'hC0}) begin
            n_fail++;
            $display("FAIL rr3_serve0: seen=%0d grant=%b data=%h, required 1 001 c0", ok, if3.out_grant, if3.out_tx_data);
        end
        if3.in_tx_hsk_ack = 1'b1;
        @(negedge clk);
        if3.in_req = 3'b000;
        if3.in_tx_hsk_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if3.out_ack, if3.out_grant, if3.out_busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL rr3_idle: ack=%b grant=%b busy=%b, required 0", if3.out_ack, if3.out_grant, if3.out_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lock_burst();
        test_ack_hold();
        test_early_drop();
        test_reset_mid_send();
        test_rr_wrap_n3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
